csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
- Machine-mode CSR file and interrupt controller for the RV32I pipeline; next generation of the existing CSR register file.
- Adds a parametrised number of platform-local interrupt lines with fixed priority, and CSR read-modify-write ops (write, set, clear).
- Adds mstatus MIE/MPIE stacking on trap entry and mret, a working vectored mtvec mode, mcycle/minstret counters and an illegal-address flag.
- Sits beside the execute/writeback boundary and drives a one-cycle PC redirect into fetch.

Parameters:
NUM_LOCAL_IRQ, 4, local interrupt lines mapped to mip/mie bits 16..16+NUM_LOCAL_IRQ-1 (1..16)
MTVEC_RESET, 32'h0000_0000, reset value of mtvec
HART_ID, 32'h0, value returned by mhartid (0xF14)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
pc  in  32  PC of oldest uncommitted instruction; saved to mepc on interrupt
csr_addr  in  12  CSR address
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
csr_wdata  in  32  operand (rs1 or zimm, already selected)
csr_rdata  out  32  old value of the addressed CSR, combinational
csr_illegal  out  1  csr_op!=00 and address unimplemented
timer_irq  in  1  level, drives mip[7]
ext_irq  in  1  level, drives mip[11]
local_irq  in  NUM_LOCAL_IRQ  level, drives mip[16+i]
is_mret  in  1  mret in commit stage
instr_retired  in  1  one instruction retired this cycle
redirect  out  1  fetch must jump to redirect_pc this cycle
redirect_pc  out  32  trap vector or mepc

Behaviour:
- Reset values: mstatus 0, mie 0, mip 0, mtvec MTVEC_RESET, mepc 0, mcause 0, mcycle 0, minstret 0. redirect=0 while reset is high.
- mip pending bits are registered copies of the interrupt lines, updated every cycle. They are read-only, and CSR writes to mip are ignored.
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00/0xB80, minstret 0xB02/0xB82, mhartid 0xF14 (read-only).
- Any other address: rdata=0 and csr_illegal=1; no state changes.
- CSR update rules:
  - New value = wdata (op 01), old|wdata (op 10), or old&~wdata (op 11), committed at the next clock edge.
  - Op 10 or 11 with wdata==0 performs no write.
- Write-field masks:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; MPP [12:11] always reads 2'b11.
  - mie: only bits 7, 11 and 16+i are writable.
  - mtvec: a mode field [1:0] of 1x keeps the previous mode.
  - mepc: bits [1:0] are forced to 0.
- Interrupt arbitration (combinational): pend = mip & mie.
  - An interrupt is taken when mstatus.MIE=1, |pend, and is_mret=0.
  - Priority: MEI (cause 11) > MTI (cause 7) > local[0] (cause 16) > local[1] > ...
- Interrupt taken:
  - redirect=1 in the same cycle.
  - redirect_pc = {mtvec[31:2],2'b00} in direct mode (00).
  - redirect_pc = {mtvec[31:2],2'b00} + 4*cause in vectored mode (01).
  - Next edge: mepc<=pc, mcause<={1'b1,cause}, MPIE<=MIE, MIE<=0.
  - Because MIE=0 afterwards, there is no re-entry until mret.
- mret:
  - redirect=1 and redirect_pc=mepc in the same cycle.
  - Next edge: MIE<=MPIE, MPIE<=1.
  - mret has priority over a simultaneous interrupt; the interrupt is taken later once MIE is restored.
- CSR write coinciding with a trap or mret: trap/mret updates of mepc, mcause and mstatus win. Writes to other CSRs in that cycle commit normally.
- Counters (64-bit):
  - mcycle increments every cycle; minstret increments when instr_retired=1.
  - Both wrap from all-ones to 0.
  - A CSR write to either half replaces that half and suppresses the increment for that cycle.
- Reset asserted mid-trap: all state returns to reset values immediately; no partial mepc/mcause update survives.

Decomposition:
- Package csr_pkg contains:
  - CSR address localparams.
  - csr_op enum.
  - Cause code constants (CAUSE_MEI=11, CAUSE_MTI=7, CAUSE_LOCAL_BASE=16).
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
- One sub-module, csr_irq_arbiter: fixed-priority encoder taking pend[31:0] and producing irq_valid and cause[4:0]; purely combinational.

Test Plan:
- mtvec=0x100 (direct), mie=0x800, mstatus=0x8, ext_irq=1, pc=0x40 -> redirect=1, redirect_pc=0x100; next cycle mepc=0x40, mcause=0x8000000B, mstatus=0x1880.
- mtvec=0x201 (vectored), timer_irq and local_irq[0] both pending and enabled -> cause 7 wins, redirect_pc=0x21C; after mret, local[0] taken with redirect_pc=0x240.
- mret with mepc=0x44 and MPIE=1, with ext_irq pending the same cycle -> redirect_pc=0x44, no trap that cycle; trap taken the next cycle.
- csr_op=10 on mstatus with wdata=0x8, then csr_op=11 with 0x8 -> rdata old values 0x1800 then 0x1808; final mstatus=0x1800.
- csr_op=01 on mcycle=0xFFFF_FFF0 -> after 16 cycles mcycleh=1, mcycle=0; writing 0x344 leaves mip unchanged; address 0x7C0 -> csr_illegal=1, rdata=0.
- Assert reset in the cycle after a trap is taken -> mepc=0, mcause=0, mstatus=0, redirect=0 immediately, regardless of clock.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encoding, trap cause codes and mstatus
// field positions for the machine-mode CSR/trap unit.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [4:0] CAUSE_MEI        = 5'd11;
   localparam logic [4:0] CAUSE_MTI        = 5'd7;
   localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   function automatic logic [31:0] csr_apply(input csr_op_e op,
                                             input logic [31:0] old_val,
                                             input logic [31:0] wdata);
      case (op)
         CSR_OP_WRITE: return wdata;
         CSR_OP_SET:   return old_val | wdata;
         CSR_OP_CLEAR: return old_val & ~wdata;
         default:      return old_val;
      endcase
   endfunction

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt encoder: MEI, then MTI, then local lines in
// ascending order. Purely combinational.
module csr_irq_arbiter
   import csr_pkg::*;
(
   input  logic [31:0] pend,
   output logic        irq_valid,
   output logic [4:0]  cause
);

   always_comb begin
      irq_valid = 1'b0;
      cause     = '0;
      // Scan from the top so the lowest-numbered local line is left standing.
      for (int i = 31; i >= int'(CAUSE_LOCAL_BASE); i--) begin
         if (pend[i]) begin
            irq_valid = 1'b1;
            cause     = 5'(i);
         end
      end
      if (pend[CAUSE_MTI]) begin
         irq_valid = 1'b1;
         cause     = CAUSE_MTI;
      end
      if (pend[CAUSE_MEI]) begin
         irq_valid = 1'b1;
         cause     = CAUSE_MEI;
      end
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt entry, mret return, 64-bit counters
// and a one-cycle PC redirect into fetch.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int          NUM_LOCAL_IRQ = 4,
   parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
   parameter logic [31:0] HART_ID       = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              pc,
   input  logic [11:0]              csr_addr,
   input  logic [1:0]               csr_op,
   input  logic [31:0]              csr_wdata,
   output logic [31:0]              csr_rdata,
   output logic                     csr_illegal,
   input  logic                     timer_irq,
   input  logic                     ext_irq,
   input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
   input  logic                     is_mret,
   input  logic                     instr_retired,
   output logic                     redirect,
   output logic [31:0]              redirect_pc
);

   localparam logic [31:0] MIE_MASK = 32'h0000_0880 |
      (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << CAUSE_LOCAL_BASE);

   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic [31:0] mie_q, mie_d, mip_q, mip_d;
   logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
   logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

   logic [31:0] mstatus_rd, csr_new, vec_base;
   logic        addr_ok, wr_en, trap_take, mret_take, trap_blk;
   logic        irq_valid;
   logic [4:0]  irq_cause;

   always_comb begin
      mstatus_rd = '0;
      mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      mstatus_rd[MSTATUS_MIE]  = mstatus_mie_q;
      mstatus_rd[MSTATUS_MPIE] = mstatus_mpie_q;
   end

   always_comb begin
      addr_ok   = 1'b1;
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus_rd;
         CSR_MIE:       csr_rdata = mie_q;
         CSR_MTVEC:     csr_rdata = mtvec_q;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MIP:       csr_rdata = mip_q;
         CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
         CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
         CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
         CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
         CSR_MHARTID:   csr_rdata = HART_ID;
         default:       addr_ok   = 1'b0;
      endcase
   end

   assign csr_illegal = (csr_op != CSR_OP_NONE) && !addr_ok;
   assign csr_new     = csr_apply(csr_op_e'(csr_op), csr_rdata, csr_wdata);
   // Set/clear with a zero mask is a pure read and must not disturb counters.
   assign wr_en       = (csr_op != CSR_OP_NONE) && addr_ok &&
                        !(csr_op[1] && (csr_wdata == 32'h0));

   csr_irq_arbiter u_arb (
      .pend      (mip_q & mie_q),
      .irq_valid (irq_valid),
      .cause     (irq_cause)
   );

   assign mret_take   = !reset && is_mret;
   assign trap_take   = !reset && mstatus_mie_q && irq_valid && !is_mret;
   assign trap_blk    = trap_take || mret_take;
   assign redirect    = trap_take || mret_take;
   assign vec_base    = {mtvec_q[31:2], 2'b00};
   assign redirect_pc = mret_take ? mepc_q :
                        (mtvec_q[1:0] == 2'b01) ? vec_base + {25'b0, irq_cause, 2'b00} :
                        vec_base;

   always_comb begin
      mip_d = '0;
      mip_d[CAUSE_MTI] = timer_irq;
      mip_d[CAUSE_MEI] = ext_irq;
      mip_d[int'(CAUSE_LOCAL_BASE) +: NUM_LOCAL_IRQ] = local_irq;
   end

   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mcycle_d       = mcycle_q + 64'd1;
      minstret_d     = minstret_q + 64'(instr_retired);
      if (wr_en) begin
         case (csr_addr)
            CSR_MSTATUS: if (!trap_blk) begin
               mstatus_mie_d  = csr_new[MSTATUS_MIE];
               mstatus_mpie_d = csr_new[MSTATUS_MPIE];
            end
            CSR_MIE:       mie_d = csr_new & MIE_MASK;
            CSR_MTVEC:     mtvec_d = {csr_new[31:2], csr_new[1] ? mtvec_q[1:0] : csr_new[1:0]};
            CSR_MEPC:      if (!trap_blk) mepc_d = {csr_new[31:2], 2'b00};
            CSR_MCAUSE:    if (!trap_blk) mcause_d = csr_new;
            CSR_MCYCLE:    mcycle_d = {mcycle_q[63:32], csr_new};
            CSR_MCYCLEH:   mcycle_d = {csr_new, mcycle_q[31:0]};
            CSR_MINSTRET:  minstret_d = {minstret_q[63:32], csr_new};
            CSR_MINSTRETH: minstret_d = {csr_new, minstret_q[31:0]};
            default: ;
         endcase
      end
      if (trap_take) begin
         mepc_d         = pc;
         mcause_d       = {1'b1, 26'b0, irq_cause};
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mip_q          <= '0;
         mtvec_q        <= MTVEC_RESET;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mip_q          <= mip_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Bench for csr_trap_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural CSR model.
module tb_csr_trap_unit;

   localparam int          NL  = 4;
   localparam logic [31:0] HID = 32'h0000_0005;
   localparam logic [31:0] MIE_WMASK = 32'h0000_0880 | (32'(((1 << NL) - 1)) << 16);

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   pc;
   logic [11:0]   csr_addr;
   logic [1:0]    csr_op;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          csr_illegal;
   logic          timer_irq, ext_irq;
   logic [NL-1:0] local_irq;
   logic          is_mret, instr_retired;
   logic          redirect;
   logic [31:0]   redirect_pc;

   always #5 clk = ~clk;

   csr_trap_unit #(.NUM_LOCAL_IRQ(NL), .MTVEC_RESET(32'h0), .HART_ID(HID)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .csr_addr      (csr_addr),
      .csr_op        (csr_op),
      .csr_wdata     (csr_wdata),
      .csr_rdata     (csr_rdata),
      .csr_illegal   (csr_illegal),
      .timer_irq     (timer_irq),
      .ext_irq       (ext_irq),
      .local_irq     (local_irq),
      .is_mret       (is_mret),
      .instr_retired (instr_retired),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc)
   );

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   // Behavioural model state
   bit          m_mie, m_mpie;
   logic [31:0] m_ie, m_ip, m_mtvec, m_mepc, m_mcause;
   logic [63:0] m_cyc, m_ins;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit m_impl(input logic [11:0] a);
      case (a)
         12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
         12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h304: return m_ie;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h344: return m_ip;
         12'hB00: return m_cyc[31:0];
         12'hB80: return m_cyc[63:32];
         12'hB02: return m_ins[31:0];
         12'hB82: return m_ins[63:32];
         12'hF14: return HID;
         default: return 32'h0;
      endcase
   endfunction

   // Highest-priority pending cause, or -1 when nothing is pending and enabled.
   function automatic int m_cause();
      logic [31:0] p;
      p = m_ip & m_ie;
      if (p[11]) return 11;
      if (p[7]) return 7;
      for (int i = 0; i < NL; i++) if (p[16+i]) return 16 + i;
      return -1;
   endfunction

   function automatic bit m_trap();
      return !reset && m_mie && (m_cause() >= 0) && !is_mret;
   endfunction

   function automatic bit m_redirect();
      return !reset && (is_mret || m_trap());
   endfunction

   function automatic logic [31:0] m_rpc();
      logic [31:0] base;
      base = m_mtvec & 32'hFFFF_FFFC;
      if (is_mret) return m_mepc;
      if (m_mtvec[1:0] == 2'b01) return base + 32'(4 * m_cause());
      return base;
   endfunction

   task automatic model_reset();
      m_mie = 0; m_mpie = 0;
      m_ie = 0; m_ip = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
      m_cyc = 0; m_ins = 0;
   endtask

   // Applies one clock edge worth of architectural effect for the current inputs.
   task automatic model_step();
      bit trap, blk, wr, cyc_w, ins_w;
      int c;
      logic [31:0] old, nv, lines;
      if (reset) begin
         model_reset();
         return;
      end
      trap = m_trap();
      c = m_cause();
      blk = trap || is_mret;
      old = m_read(csr_addr);
      wr = (csr_op != 0) && m_impl(csr_addr) && !(csr_op >= 2 && csr_wdata == 0);
      case (csr_op)
         2'd1: nv = csr_wdata;
         2'd2: nv = old | csr_wdata;
         2'd3: nv = old & ~csr_wdata;
         default: nv = old;
      endcase
      cyc_w = 0; ins_w = 0;
      if (wr) begin
         case (csr_addr)
            12'h300: if (!blk) begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_ie = nv & MIE_WMASK;
            12'h305: m_mtvec = {nv[31:2], (nv[1] ? m_mtvec[1:0] : nv[1:0])};
            12'h341: if (!blk) m_mepc = nv & 32'hFFFF_FFFC;
            12'h342: if (!blk) m_mcause = nv;
            12'hB00: begin m_cyc[31:0] = nv; cyc_w = 1; end
            12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1; end
            12'hB02: begin m_ins[31:0] = nv; ins_w = 1; end
            12'hB82: begin m_ins[63:32] = nv; ins_w = 1; end
            default: ;
         endcase
      end
      if (!cyc_w) m_cyc = m_cyc + 64'd1;
      if (!ins_w) m_ins = m_ins + (instr_retired ? 64'd1 : 64'd0);
      if (trap) begin
         m_mepc = pc;
         m_mcause = 32'h8000_0000 | 32'(c);
         m_mpie = m_mie;
         m_mie = 0;
      end else if (is_mret) begin
         m_mie = m_mpie;
         m_mpie = 1;
      end
      lines = 0;
      lines[7] = timer_irq;
      lines[11] = ext_irq;
      for (int i = 0; i < NL; i++) lines[16+i] = local_irq[i];
      m_ip = lines;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rdata", csr_rdata, m_read(csr_addr));
         check("illegal", {31'b0, csr_illegal}, {31'b0, (csr_op != 0) && !m_impl(csr_addr)});
         check("redirect", {31'b0, redirect}, {31'b0, m_redirect()});
         if (m_redirect()) check("redirect_pc", redirect_pc, m_rpc());
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csr_addr = a; csr_op = 2'd1; csr_wdata = d;
      tick();
      csr_op = 2'd0;
   endtask

   task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a; csr_op = 2'd0;
      #1;
      check(name, csr_rdata, exp);
   endtask

   task automatic redir_chk(input string name, input logic [31:0] exp_pc);
      #1;
      check({name, "_redirect"}, {31'b0, redirect}, 32'd1);
      check({name, "_pc"}, redirect_pc, exp_pc);
   endtask

   logic [11:0] addr_tab [13] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                                  12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h123};

   initial begin
      reset = 1; pc = 0; csr_addr = 12'h300; csr_op = 0; csr_wdata = 0;
      timer_irq = 0; ext_irq = 0; local_irq = 0; is_mret = 0; instr_retired = 0;
      model_reset();
      chk_en = 1;
      #1;
      check("rst_mstatus", csr_rdata, 32'h0000_1800);
      check("rst_redirect", {31'b0, redirect}, 32'd0);
      rd_chk("rst_mtvec", 12'h305, 32'h0);
      rd_chk("rst_mcycle", 12'hB00, 32'h0);
      tick(); tick();
      reset = 0;

      // Direct-mode external interrupt
      wr(12'h305, 32'h100);
      wr(12'h304, 32'h800);
      wr(12'h300, 32'h8);
      ext_irq = 1; pc = 32'h40;
      tick();
      redir_chk("t1", 32'h100);
      tick();
      rd_chk("t1_mepc", 12'h341, 32'h40);
      rd_chk("t1_mcause", 12'h342, 32'h8000_000B);
      rd_chk("t1_mstatus", 12'h300, 32'h0000_1880);
      check("t1_no_reentry", {31'b0, redirect}, 32'd0);

      // Vectored mode: MTI beats local[0], then local[0] after mret
      ext_irq = 0;
      wr(12'h304, 32'h0001_0080);
      timer_irq = 1; local_irq = 4'b0001;
      wr(12'h305, 32'h201);
      csr_addr = 12'h300; csr_op = 2'd2; csr_wdata = 32'h8;
      tick();
      csr_op = 0; pc = 32'h80;
      redir_chk("t2_mti", 32'h21C);
      tick();
      is_mret = 1; timer_irq = 0;
      redir_chk("t2_mret", 32'h80);
      tick();
      is_mret = 0; pc = 32'h90;
      redir_chk("t2_local0", 32'h240);
      tick();
      rd_chk("t2_mcause", 12'h342, 32'h8000_0010);

      // mret wins over a simultaneous external interrupt
      local_irq = 0;
      wr(12'h341, 32'h44);
      wr(12'h304, 32'h800);
      ext_irq = 1;
      tick();
      is_mret = 1;
      redir_chk("t3_mret", 32'h44);
      tick();
      is_mret = 0; pc = 32'hA0;
      redir_chk("t3_late", 32'h22C);
      rd_chk("t3_mcause_hold", 12'h342, 32'h8000_0010);
      tick();
      rd_chk("t3_mcause", 12'h342, 32'h8000_000B);
      rd_chk("t3_mepc", 12'h341, 32'hA0);
      ext_irq = 0;

      // Set/clear on mstatus
      wr(12'h300, 32'h0);
      csr_addr = 12'h300; csr_op = 2'd2; csr_wdata = 32'h8;
      #1 check("t4_set_old", csr_rdata, 32'h1800);
      tick();
      csr_op = 2'd3; csr_wdata = 32'h8;
      #1 check("t4_clr_old", csr_rdata, 32'h1808);
      tick();
      rd_chk("t4_final", 12'h300, 32'h1800);

      // Counter wrap, read-only mip, illegal address, mhartid
      wr(12'hB80, 32'h0);
      wr(12'hB00, 32'hFFFF_FFF0);
      repeat (16) tick();
      rd_chk("t5_mcycleh", 12'hB80, 32'h1);
      rd_chk("t5_mcycle", 12'hB00, 32'h0);
      ext_irq = 1;
      tick();
      wr(12'h344, 32'h0);
      rd_chk("t5_mip_ro", 12'h344, 32'h800);
      ext_irq = 0;
      csr_addr = 12'h7C0; csr_op = 2'd1; csr_wdata = 32'hFFFF;
      #1 check("t5_illegal", {31'b0, csr_illegal}, 32'd1);
      check("t5_illegal_rdata", csr_rdata, 32'h0);
      csr_op = 0;
      #1 check("t5_noop_legal", {31'b0, csr_illegal}, 32'd0);
      rd_chk("t5_mhartid", 12'hF14, HID);
      tick();

      // Asynchronous reset right after a trap
      wr(12'h305, 32'h100);
      ext_irq = 1;
      tick();
      wr(12'h300, 32'h8);
      pc = 32'hC0;
      redir_chk("t6", 32'h100);
      tick();
      csr_addr = 12'h341;
      reset = 1;
      model_reset();
      #1 check("t6_mepc", csr_rdata, 32'h0);
      check("t6_redirect", {31'b0, redirect}, 32'd0);
      is_mret = 1;
      #1 check("t6_mret_in_reset", {31'b0, redirect}, 32'd0);
      is_mret = 0;
      rd_chk("t6_mcause", 12'h342, 32'h0);
      rd_chk("t6_mstatus", 12'h300, 32'h1800);
      ext_irq = 0;
      tick(); tick();
      reset = 0;
      tick();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         csr_addr = addr_tab[$urandom_range(0, 12)];
         csr_op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: csr_wdata = 32'h0;
            1: csr_wdata = 32'h8 << ($urandom_range(0, 1) * 4);
            default: csr_wdata = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) timer_irq = ~timer_irq;
         if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
         for (int i = 0; i < NL; i++) if ($urandom_range(0, 7) == 0) local_irq[i] = ~local_irq[i];
         is_mret = ($urandom_range(0, 9) == 0);
         instr_retired = 1'($urandom_range(0, 1));
         pc = $urandom & 32'hFFFF_FFFC;
         if (n == 1500) begin
            reset = 1;
            model_reset();
         end else begin
            reset = 0;
         end
         tick();
      end
      reset = 0; csr_op = 0; is_mret = 0;
      tick();
      chk_en = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
